// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states, defaults.
package alu_share_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned OPW_DEF   = 3;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_NOR   = 3'b101;
  localparam logic [2:0] OP_SLT   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (op, a, b) -> (res, zero). Arithmetic wraps, carry is dropped.
module alu_core
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt_signed;

  assign sum       = a + b;
  assign diff      = a - b;
  assign lt_signed = $signed(a) < $signed(b);

  // Opcode select; SLT result is the single compare bit zero-extended.
  always_comb begin
    res = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_ADD:   res = sum;
      OP_SUB:   res = diff;
      OP_XOR:   res = a ^ b;
      OP_NOR:   res = ~(a | b);
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters with a registered,
// held-until-accepted result per requester.
//
//   state | meaning
//   IDLE  | arbitrate; accept one request and latch op/a/b/owner
//   EXEC  | ALU evaluates latched operands; result registered to owner
//   RESP  | owner's response held valid until its rsp_ready
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_res,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_res,
  output logic             rsp1_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_res_q, rsp0_res_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_res_q, rsp1_res_d;
  logic             rsp1_zero_q, rsp1_zero_d;

  logic             gnt_valid;
  logic             gnt_id;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

  alu_core #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .res  (alu_res),
    .zero (alu_zero)
  );

  // Round-robin pick: on contention the requester that did not go last wins.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && gnt_valid && (gnt_id == 1'b0);
  assign req1_ready = (state_q == IDLE) && gnt_valid && (gnt_id == 1'b1);

  // Next-state and datapath updates; the non-owner response registers are never touched.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_res_d   = rsp0_res_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_res_d   = rsp1_res_q;
    rsp1_zero_d  = rsp1_zero_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_id;
          op_d    = gnt_id ? req1_op : req0_op;
          a_d     = gnt_id ? req1_a  : req0_a;
          b_d     = gnt_id ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          rsp1_res_d   = alu_res;
          rsp1_zero_d  = alu_zero;
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_res_d   = alu_res;
          rsp0_zero_d  = alu_zero;
          rsp0_valid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (!owner_q && rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end else if (owner_q && rsp1_ready) begin
          rsp1_valid_d = 1'b0;
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_res_q   <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_res_q   <= '0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_res_q   <= rsp0_res_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_res_q   <= rsp1_res_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_res   = rsp0_res_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_res   = rsp1_res_q;
  assign rsp1_zero  = rsp1_zero_q;
  assign busy       = (state_q != IDLE);

endmodule
